// File: rtl/dut_cmd_controller.sv
// rtl/dut_cmd_controller.sv - byte-stream command parser and DUT transaction sequencer
// Parses 4-byte frames, drives write/read/start/header transactions and serialises the response bytes.
module dut_cmd_controller #(
    parameter int BITWIDTH_DATA   = 16,
    parameter int BITWIDTH_ADR    = 6,
    parameter int NUM_BITS_HEADER = 32,
    parameter int READ_WAIT       = 2,
    parameter int CALC_TIMEOUT    = 65535,
    parameter int FRAME_TIMEOUT   = 100000
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [7:0]                 RX_DATA,
    input  logic                       RX_VALID,
    output logic [7:0]                 TX_DATA,
    output logic                       TX_VALID,
    input  logic                       TX_READY,
    output logic [5:0]                 SEL,
    output logic [BITWIDTH_ADR-1:0]    ADR,
    output logic                       RnW,
    output logic [BITWIDTH_DATA-1:0]   DATA_IN,
    output logic                       START_FLAG,
    input  logic [BITWIDTH_DATA-1:0]   DATA_OUT,
    input  logic [NUM_BITS_HEADER-1:0] HEAD_INFO,
    input  logic                       RDY_FLAG,
    output logic                       BUSY,
    output logic                       ERR_DROP
);

    localparam int CW = $clog2(CALC_TIMEOUT + 1);
    localparam int FW = $clog2(FRAME_TIMEOUT + 1);
    localparam int RW = (READ_WAIT > 1) ? $clog2(READ_WAIT + 1) : 1;

    localparam logic [1:0] CMD_WRITE  = 2'b00;
    localparam logic [1:0] CMD_READ   = 2'b01;
    localparam logic [1:0] CMD_START  = 2'b10;
    localparam logic [1:0] CMD_HEADER = 2'b11;

    typedef enum logic [1:0] {
        S_RX,
        S_EXEC,
        S_WAIT,
        S_TX
    } state_t;

    state_t                    state_q;
    logic [1:0]                byte_cnt_q;
    logic [7:0]                b0_q;
    logic [BITWIDTH_ADR-1:0]   adr_byte_q;
    logic [7:0]                b2_q;
    logic [1:0]                cmd_q;
    logic [5:0]                sel_q;
    logic [BITWIDTH_ADR-1:0]   adr_q;
    logic                      rnw_q;
    logic [BITWIDTH_DATA-1:0]  data_in_q;
    logic                      start_q;
    logic [7:0]                tx_data_q;
    logic                      tx_valid_q;
    logic                      err_q;
    logic [FW-1:0]             idle_q;
    logic [CW-1:0]             wait_q;
    logic [RW-1:0]             exec_q;
    logic [31:0]               resp_q;
    logic [1:0]                left_q;

    logic [31:0]               resp_d;
    logic [1:0]                left_d;
    logic                      load_tx_d;

    // Response word is left-aligned so every command shifts out MSB first.
    always_comb begin
        resp_d = {8'hA5, 24'h000000};
        left_d = 2'd0;
        case (cmd_q)
            CMD_READ: begin
                resp_d = {DATA_OUT, 16'h0000};
                left_d = 2'd1;
            end
            CMD_HEADER: begin
                resp_d = HEAD_INFO;
                left_d = 2'd3;
            end
            CMD_START: begin
                if (!RDY_FLAG) begin
                    resp_d = {8'hEE, 24'h000000};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        load_tx_d = 1'b0;
        if (state_q == S_EXEC) begin
            case (cmd_q)
                CMD_WRITE:  load_tx_d = (exec_q != '0);
                CMD_READ:   load_tx_d = (exec_q == RW'(READ_WAIT - 1));
                CMD_HEADER: load_tx_d = 1'b1;
                default:    load_tx_d = 1'b0;
            endcase
        end else if (state_q == S_WAIT && !start_q) begin
            // Ready on the final timeout cycle still yields the success byte.
            load_tx_d = RDY_FLAG || (wait_q == CW'(CALC_TIMEOUT - 1));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_RX;
            byte_cnt_q <= 2'd0;
            b0_q       <= 8'h00;
            adr_byte_q <= '0;
            b2_q       <= 8'h00;
            cmd_q      <= CMD_WRITE;
            sel_q      <= 6'd0;
            adr_q      <= '0;
            rnw_q      <= 1'b1;
            data_in_q  <= '0;
            start_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            idle_q     <= '0;
            wait_q     <= '0;
            exec_q     <= '0;
            resp_q     <= 32'h0;
            left_q     <= 2'd0;
        end else begin
            start_q <= 1'b0;
            rnw_q   <= 1'b1;
            if (RX_VALID && state_q != S_RX) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_RX: begin
                    if (RX_VALID) begin
                        idle_q     <= '0;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: b0_q       <= RX_DATA;
                            2'd1: adr_byte_q <= RX_DATA[BITWIDTH_ADR-1:0];
                            2'd2: b2_q       <= RX_DATA;
                            default: begin
                                cmd_q  <= b0_q[7:6];
                                sel_q  <= b0_q[5:0];
                                adr_q  <= adr_byte_q;
                                exec_q <= '0;
                                if (b0_q[7:6] == CMD_WRITE) begin
                                    data_in_q <= {b2_q, RX_DATA};
                                end
                                state_q <= S_EXEC;
                            end
                        endcase
                    end else if (byte_cnt_q != 2'd0) begin
                        if (idle_q == FW'(FRAME_TIMEOUT - 1)) begin
                            byte_cnt_q <= 2'd0;
                            idle_q     <= '0;
                        end else begin
                            idle_q <= idle_q + FW'(1);
                        end
                    end
                end
                S_EXEC: begin
                    case (cmd_q)
                        CMD_WRITE: begin
                            if (exec_q == '0) begin
                                rnw_q  <= 1'b0;
                                exec_q <= RW'(1);
                            end
                        end
                        CMD_READ: exec_q <= exec_q + RW'(1);
                        CMD_START: begin
                            start_q <= 1'b1;
                            wait_q  <= '0;
                            state_q <= S_WAIT;
                        end
                        default: ;
                    endcase
                end
                S_WAIT: begin
                    if (!start_q) begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                S_TX: begin
                    if (tx_valid_q && TX_READY) begin
                        if (left_q != 2'd0) begin
                            tx_data_q <= resp_q[31:24];
                            resp_q    <= {resp_q[23:0], 8'h00};
                            left_q    <= left_q - 2'd1;
                        end else begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_RX;
                        end
                    end
                end
                default: state_q <= S_RX;
            endcase
            if (load_tx_d) begin
                tx_data_q  <= resp_d[31:24];
                resp_q     <= {resp_d[23:0], 8'h00};
                left_q     <= left_d;
                tx_valid_q <= 1'b1;
                state_q    <= S_TX;
            end
        end
    end

    assign TX_DATA    = tx_data_q;
    assign TX_VALID   = tx_valid_q;
    assign SEL        = sel_q;
    assign ADR        = adr_q;
    assign RnW        = rnw_q;
    assign DATA_IN    = data_in_q;
    assign START_FLAG = start_q;
    assign BUSY       = (state_q != S_RX);
    assign ERR_DROP   = err_q;

endmodule

// File: tb/tb_dut_cmd_controller.sv
// tb/tb_dut_cmd_controller.sv - randomized self-checking bench for dut_cmd_controller
module tb_dut_cmd_controller;

    localparam int RWAIT = 2;
    localparam int CT    = 40;
    localparam int FT    = 30;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b1;
    logic [5:0]  SEL;
    logic [5:0]  ADR;
    logic        RnW;
    logic [15:0] DATA_IN;
    logic        START_FLAG;
    logic [15:0] DATA_OUT = 16'h0000;
    logic [31:0] HEAD_INFO = 32'h0;
    logic        RDY_FLAG = 1'b0;
    logic        BUSY;
    logic        ERR_DROP;

    dut_cmd_controller #(
        .BITWIDTH_DATA(16), .BITWIDTH_ADR(6), .NUM_BITS_HEADER(32),
        .READ_WAIT(RWAIT), .CALC_TIMEOUT(CT), .FRAME_TIMEOUT(FT)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .SEL(SEL), .ADR(ADR), .RnW(RnW), .DATA_IN(DATA_IN), .START_FLAG(START_FLAG),
        .DATA_OUT(DATA_OUT), .HEAD_INFO(HEAD_INFO), .RDY_FLAG(RDY_FLAG),
        .BUSY(BUSY), .ERR_DROP(ERR_DROP)
    );

    always #5 CLK = ~CLK;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    int          rnw_low_cnt = 0;
    int          start_cnt = 0;
    int          tx_valid_cnt = 0;
    int          ready_mode = 0;
    int          exp_rnw = 0;
    int          exp_start = 0;
    logic [5:0]  exp_sel = 6'd0;
    logic [5:0]  exp_adr = 6'd0;
    logic [15:0] exp_data = 16'h0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_rst = 1'b1;
    logic [7:0]  prev_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic mon_step();
        logic [7:0] e;
        if (!RST) begin
            if (prev_valid && !prev_ready && !prev_rst) begin
                check("tx_hold_valid", TX_VALID, 1);
                check("tx_hold_data", TX_DATA, prev_data);
            end
            if (TX_VALID) begin
                tx_valid_cnt++;
                check("busy_during_tx", BUSY, 1);
            end
            if (TX_VALID && TX_READY) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_unexpected: actual=%0h required=none", TX_DATA);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", TX_DATA, e);
                end
            end
            if (!RnW) begin
                rnw_low_cnt++;
                check("wr_sel", SEL, exp_sel);
                check("wr_adr", ADR, exp_adr);
                check("wr_data", DATA_IN, exp_data);
            end
            if (START_FLAG) start_cnt++;
        end
        prev_valid = TX_VALID;
        prev_ready = TX_READY;
        prev_data  = TX_DATA;
        prev_rst   = RST;
    endtask

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        sync();
        RX_VALID = 1'b0;
        repeat (gap) sync();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sel"}, SEL, 0);
        check({tag, "_adr"}, ADR, 0);
        check({tag, "_rnw"}, RnW, 1);
        check({tag, "_data_in"}, DATA_IN, 0);
        check({tag, "_start"}, START_FLAG, 0);
        check({tag, "_tx_data"}, TX_DATA, 0);
        check({tag, "_tx_valid"}, TX_VALID, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_err"}, ERR_DROP, 0);
    endtask

    // Model: frame fields and the response each command must produce.
    task automatic issue_cmd(input logic [1:0] cmd, input logic [5:0] sel, input logic [7:0] adrb,
                             input logic [7:0] hi, input logic [7:0] lo,
                             input logic [7:0] start_resp, input int mid_gap);
        exp_sel   = sel;
        exp_adr   = adrb[5:0];
        if (cmd == 2'b00) exp_data = {hi, lo};
        exp_rnw   = (cmd == 2'b00) ? 1 : 0;
        exp_start = (cmd == 2'b10) ? 1 : 0;
        rnw_low_cnt = 0;
        start_cnt   = 0;
        case (cmd)
            2'b00: exp_q.push_back(8'hA5);
            2'b01: begin
                exp_q.push_back(DATA_OUT[15:8]);
                exp_q.push_back(DATA_OUT[7:0]);
            end
            2'b10: exp_q.push_back(start_resp);
            default: for (int i = 3; i >= 0; i--) exp_q.push_back(HEAD_INFO[i*8 +: 8]);
        endcase
        send_byte({cmd, sel}, $urandom_range(0, 2));
        send_byte(adrb, mid_gap);
        send_byte(hi, $urandom_range(0, 2));
        send_byte(lo, 0);
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (START_FLAG) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL start_timeout: actual=no_pulse required=pulse");
        end
    endtask

    task automatic raise_rdy_after(input int d);
        repeat (d) @(posedge CLK);
        #1;
        RDY_FLAG = 1'b1;
    endtask

    task automatic wait_tx_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (TX_VALID) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL tx_valid_timeout: actual=0 required=1");
        end
    endtask

    task automatic finish_cmd(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !BUSY) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: actual=pending%0d required=0", tag, exp_q.size());
            exp_q.delete();
        end
        sync();
        RDY_FLAG = 1'b0;
        check({tag, "_rnw_pulses"}, rnw_low_cnt, exp_rnw);
        check({tag, "_start_pulses"}, start_cnt, exp_start);
        check({tag, "_sel"}, SEL, exp_sel);
        check({tag, "_adr"}, ADR, exp_adr);
        check({tag, "_data_in"}, DATA_IN, exp_data);
    endtask

    initial begin
        bit          found;
        logic [1:0]  cmd;
        int          d;
        fork
            forever @(negedge CLK) mon_step();
            forever begin
                @(posedge CLK);
                #1;
                if (ready_mode == 0) TX_READY = 1'b1;
                else if (ready_mode == 1) TX_READY = ($urandom_range(0, 2) != 0);
            end
        join_none

        repeat (3) sync();
        RST = 1'b0;
        @(negedge CLK);
        check_reset_values("reset");
        sync();

        // WRITE with literal expectations
        issue_cmd(2'b00, 6'h03, 8'h05, 8'h12, 8'h34, 8'h00, 0);
        finish_cmd("t1_write");
        check("t1_sel_lit", SEL, 6'h03);
        check("t1_data_lit", DATA_IN, 16'h1234);

        // READ, SEL/ADR unchanged values, DATA_IN retained
        DATA_OUT = 16'hBEEF;
        issue_cmd(2'b01, 6'h03, 8'h05, 8'h77, 8'h88, 8'h00, 1);
        check("t2_model_lit", {exp_q[0], exp_q[1]}, 16'hBEEF);
        finish_cmd("t2_read");

        // START: ready after 10, never, and at the timeout boundary
        issue_cmd(2'b10, 6'h02, 8'h01, 8'h00, 8'h00, 8'hA5, 0);
        wait_start(found);
        if (found) raise_rdy_after(10);
        finish_cmd("t3_start_rdy");
        issue_cmd(2'b10, 6'h02, 8'h01, 8'h00, 8'h00, 8'hEE, 0);
        finish_cmd("t3_start_timeout");
        issue_cmd(2'b10, 6'h02, 8'h01, 8'h00, 8'h00, 8'hA5, 0);
        wait_start(found);
        if (found) raise_rdy_after(CT);
        finish_cmd("t3_start_coincide");
        issue_cmd(2'b10, 6'h02, 8'h01, 8'h00, 8'h00, 8'hEE, 0);
        wait_start(found);
        if (found) raise_rdy_after(CT + 1);
        finish_cmd("t3_start_late");

        // HEADER with TX_READY held low before the second byte
        HEAD_INFO  = 32'h04012345;
        ready_mode = 2;
        TX_READY   = 1'b0;
        issue_cmd(2'b11, 6'h01, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        check("t4_model_lit", {exp_q[0], exp_q[1], exp_q[2], exp_q[3]}, 32'h04012345);
        wait_tx_valid();
        check("t4_first_byte", TX_DATA, 8'h04);
        sync();
        TX_READY = 1'b1;
        sync();
        TX_READY = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            check("t4_stall_valid", TX_VALID, 1);
            check("t4_stall_data", TX_DATA, 8'h01);
        end
        sync();
        ready_mode = 0;
        TX_READY   = 1'b1;
        finish_cmd("t4_header");

        // Randomized commands
        for (int n = 0; n < 40; n++) begin
            cmd        = 2'($urandom_range(0, 3));
            DATA_OUT   = 16'($urandom);
            HEAD_INFO  = $urandom;
            ready_mode = $urandom_range(0, 1);
            d          = $urandom_range(1, CT + 4);
            issue_cmd(cmd, 6'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      (d <= CT) ? 8'hA5 : 8'hEE, $urandom_range(0, 3));
            if (cmd == 2'b10) begin
                wait_start(found);
                if (found) raise_rdy_after(d);
            end
            finish_cmd("rand");
        end
        ready_mode = 0;
        check("rand_err_clear", ERR_DROP, 0);

        // Longest legal inter-byte gap keeps the frame
        issue_cmd(2'b00, 6'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00, FT - 1);
        finish_cmd("t5_gap_ok");

        // Idle timeout discards a partial frame
        send_byte(8'h81, 1);
        send_byte(8'h07, FT + 3);
        issue_cmd(2'b00, 6'h05, 8'h09, 8'hAB, 8'hCD, 8'h00, 0);
        finish_cmd("t5_timeout");
        check("t5_err_still_clear", ERR_DROP, 0);

        // Byte during S_TX is dropped and sets ERR_DROP
        ready_mode = 2;
        TX_READY   = 1'b0;
        issue_cmd(2'b00, 6'h11, 8'h22, 8'h5A, 8'h5A, 8'h00, 0);
        wait_tx_valid();
        sync();
        send_byte(8'hC0, 0);
        @(negedge CLK);
        check("t5_err_drop", ERR_DROP, 1);
        sync();
        ready_mode = 0;
        TX_READY   = 1'b1;
        finish_cmd("t5_drop_write");
        DATA_OUT = 16'h00C3;
        issue_cmd(2'b01, 6'h00, 8'h3F, 8'h00, 8'h00, 8'h00, 0);
        finish_cmd("t5_sel0_read");
        check("t5_err_sticky", ERR_DROP, 1);

        // Reset during S_WAIT drops the pending response
        issue_cmd(2'b10, 6'h07, 8'h03, 8'h00, 8'h00, 8'hEE, 0);
        wait_start(found);
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_reset_values("t6_reset");
        exp_q.delete();
        tx_valid_cnt = 0;
        sync();
        RST = 1'b0;
        repeat (CT + 10) sync();
        check("t6_no_tx", tx_valid_cnt, 0);
        check("t6_busy", BUSY, 0);

        // Reset mid-frame discards the partial bytes
        send_byte(8'h43, 0);
        send_byte(8'h05, 0);
        RST = 1'b1;
        sync();
        RST = 1'b0;
        exp_data = 16'h0;
        DATA_OUT = 16'h1357;
        issue_cmd(2'b01, 6'h03, 8'h05, 8'h00, 8'h00, 8'h00, 0);
        finish_cmd("t6_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
